irq_request_collector: RTL and testbench
========================================

Name: irq_request_collector

Overview:
Upstream front end for the 8-input priority encoder. It synchronises raw request lines and captures edge-type requests in a pending register. It presents the masked pending vector to the encoder and runs a claim/complete handshake using the encoder's n+1 index code. It clears serviced requests and blocks re-issue of the in-service line until the consumer signals completion.

Parameters:
N, 8, number of request lines; must equal the encoder input width.
SYNC_STAGES, 2, flip-flop stages per line in the input synchroniser; legal range 2..3.
IDW, $clog2(N+1), width of the n+1 index code; 4 for N=8.

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk externally
irq_i  input  N  raw asynchronous request lines
edge_sel_i  input  N  per line: 1 = rising-edge captured, 0 = level
mask_i  input  N  per line: 1 = hide from pend_o; pending state is still kept
pend_o  output  N  masked pending vector; drives encoder input a
req_valid_o  output  1  at least one unmasked request is available and the block is idle
claim_i  input  1  consumer takes the request identified by claim_id_i
claim_id_i  input  IDW  n+1 code from the encoder; 0 = none, k = line k-1
active_o  output  1  a request is in service
active_id_o  output  IDW  code of the in-service line; 0 when idle
complete_i  input  1  consumer finished the in-service request
claim_err_o  output  1  sticky: an illegal claim was attempted

Behaviour:
- Reset (rst_n=0, asynchronous): synchroniser flops, edge-history flops and the pending register go to 0. State = IDLE. Outputs: pend_o=0, req_valid_o=0, active_o=0, active_id_o=0, claim_err_o=0.
- Synchroniser: SYNC_STAGES flops per line, giving sync[i]. The edge detector compares sync[i] with its value one cycle earlier.
- Edge lines: pend_q[i] sets on a rising edge of sync[i]. It clears on an accepted claim of code i+1. If set and clear coincide, set wins.
- Level lines: pend_q[i] = sync[i], registered every cycle. A claim does not clear it.
- Changing edge_sel_i[i] clears pend_q[i] in the same cycle.
- pend_o = pend_q & ~mask_i & ~inservice_onehot. This is combinational from registers and mask_i.
- req_valid_o = (state==IDLE) & |pend_o.
- Latency, edge line with mask=0: irq_i rising to pend_o[i] = SYNC_STAGES+1 cycles (3 with defaults).
- FSM IDLE:
  - A claim is accepted when claim_i=1, 1 <= claim_id_i <= N and pend_o[claim_id_i-1]=1.
  - On acceptance: latch active_id, clear the pending bit (edge lines), go to SERVICE. active_o=1 from the next cycle.
  - A claim with code 0, code > N, or a non-pending/masked line is ignored. It sets claim_err_o and the state is unchanged.
  - complete_i in IDLE is ignored.
- FSM SERVICE:
  - req_valid_o=0. The in-service line is forced out of pend_o; other lines still show.
  - complete_i=1 returns the block to IDLE next cycle and sets active_id_o=0.
  - claim_i in SERVICE is ignored and sets claim_err_o.
  - claim_i and complete_i in the same SERVICE cycle: complete takes effect, claim is ignored and does not set the error.
  - A new edge on the in-service line during SERVICE sets pend_q again. It becomes visible after completion.
- claim_err_o clears only on reset.
- Reset mid-SERVICE: returns to IDLE immediately and discards all pending state.

Optional Feature:
IRQ_OVERRUN_EN:
- Defined: adds output overrun_o[N-1:0]. Bit i is sticky-set when an edge arrives on an edge line whose pend_q[i] is already 1 and not being cleared that cycle. It clears on an accepted claim of that line. Reset value 0.
- Undefined: the port and its logic are absent. Repeated edges merge silently into one pending bit.

Test Plan:
- Reset with irq_i=8'hFF and level mode: all outputs 0 during reset. After release, pend_o=8'hFF and req_valid_o=1 after 3 cycles.
- Edge line 5 (edge_sel=8'h20), pulse irq_i[5] for 1 cycle: pend_o=8'h20 at cycle 3. Claim code 6 -> active_id_o=6, pend_o=8'h00, req_valid_o=0. complete_i -> active_o=0.
- Pending lines 2 and 7, mask_i=8'h80: pend_o=8'h04. A claim of code 8 is rejected (claim_err_o=1, still IDLE). A claim of code 3 is accepted.
- During SERVICE of line 0 (edge), pulse irq_i[0] again: pend_o[0] stays 0 until complete, then 1 on the following cycle. req_valid_o=1.
- Claim and new edge on the same line in the same cycle: pend_q bit stays 1 (set wins). With IRQ_OVERRUN_EN, two edges before a claim give overrun_o[i]=1, which clears on claim.
- Assert rst_n=0 mid-SERVICE with line 3 pending: all outputs 0 asynchronously, before the next clk edge. After release the block is IDLE with pend_o=0.

Source files
------------

// File: rtl/irq_request_collector.sv
// irq_request_collector
//   Front end for an N-input priority encoder. It synchronises the raw request
//   lines and holds edge or level requests in a pending register. It shows the
//   masked pending vector to the encoder and runs a claim/complete handshake
//   using the encoder's n+1 index code (0 = none, k = line k-1).
//   Optional feature macro: IRQ_OVERRUN_EN adds the sticky overrun_o vector.
module irq_request_collector #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int IDW         = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   irq_i,
  input  logic [N-1:0]   edge_sel_i,
  input  logic [N-1:0]   mask_i,
  output logic [N-1:0]   pend_o,
  output logic           req_valid_o,
  input  logic           claim_i,
  input  logic [IDW-1:0] claim_id_i,
  output logic           active_o,
  output logic [IDW-1:0] active_id_o,
  input  logic           complete_i,
  output logic           claim_err_o
`ifdef IRQ_OVERRUN_EN
  ,
  output logic [N-1:0]   overrun_o
`endif
);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  state_t         state_q;
  logic [N-1:0]   sync_q [SYNC_STAGES];
  logic [N-1:0]   sync_bits;
  logic [N-1:0]   prev_q;
  logic [N-1:0]   rise;
  logic [N-1:0]   esel_q;
  logic [N-1:0]   esel_chg;
  logic [N-1:0]   pend_q;
  logic [N-1:0]   claim_hit;
  logic [N-1:0]   svc_hit;
  logic [N-1:0]   pend_clr;
  logic           accept;

  // Multi-stage synchroniser per request line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_bits = sync_q[SYNC_STAGES-1];
  assign rise      = sync_bits & ~prev_q;
  assign esel_chg  = edge_sel_i ^ esel_q;

  // One-hot decode of the claim code and of the in-service code; code 0 and
  // codes above N decode to no line at all.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
      assign claim_hit[gi] = (claim_id_i  == IDW'(gi + 1));
      assign svc_hit[gi]   = (active_id_o == IDW'(gi + 1));
    end
  endgenerate

  // active_id_o is 0 when idle, so svc_hit only hides a line during SERVICE
  assign pend_o      = pend_q & ~mask_i & ~svc_hit;
  assign req_valid_o = (state_q == IDLE) && (|pend_o);
  assign accept      = (state_q == IDLE) && claim_i && (|(claim_hit & pend_o));
  assign pend_clr    = accept ? claim_hit : '0;

  // Pending register: mode change clears, level follows sync, edge sets over claim-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      prev_q <= '0;
      esel_q <= '0;
    end else begin
      prev_q <= sync_bits;
      esel_q <= edge_sel_i;
      for (int i = 0; i < N; i++) begin
        if (esel_chg[i])         pend_q[i] <= 1'b0;
        else if (!edge_sel_i[i]) pend_q[i] <= sync_bits[i];
        else if (rise[i])        pend_q[i] <= 1'b1;
        else if (pend_clr[i])    pend_q[i] <= 1'b0;
      end
    end
  end

  // Claim/complete handshake with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      active_o    <= 1'b0;
      active_id_o <= '0;
      claim_err_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= SERVICE;
            active_o    <= 1'b1;
            active_id_o <= claim_id_i;
          end else if (claim_i) begin
            claim_err_o <= 1'b1;
          end
        end
        SERVICE: begin
          if (complete_i) begin
            state_q     <= IDLE;
            active_o    <= 1'b0;
            active_id_o <= '0;
          end else if (claim_i) begin
            claim_err_o <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IRQ_OVERRUN_EN
  logic [N-1:0] ovr_set;
  assign ovr_set = edge_sel_i & ~esel_chg & rise & pend_q & ~pend_clr;

  // Sticky overrun flag per edge line, cleared by an accepted claim of that line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_o <= '0;
    else        overrun_o <= (overrun_o & ~pend_clr) | ovr_set;
  end
`endif

endmodule

// File: tb/tb_irq_request_collector.sv
// tb_irq_request_collector
//   Directed scenarios followed by a randomized run, all checked against a
//   behavioural model of the request collector held in the bench.
module tb_irq_request_collector;
  localparam int N   = 8;
  localparam int S   = 2;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   irq_i = '0;
  logic [N-1:0]   edge_sel_i = '0;
  logic [N-1:0]   mask_i = '0;
  logic [N-1:0]   pend_o;
  logic           req_valid_o;
  logic           claim_i = 1'b0;
  logic [IDW-1:0] claim_id_i = '0;
  logic           active_o;
  logic [IDW-1:0] active_id_o;
  logic           complete_i = 1'b0;
  logic           claim_err_o;
`ifdef IRQ_OVERRUN_EN
  logic [N-1:0]   overrun_o;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  irq_request_collector #(.N(N), .SYNC_STAGES(S), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_i       (irq_i),
    .edge_sel_i  (edge_sel_i),
    .mask_i      (mask_i),
    .pend_o      (pend_o),
    .req_valid_o (req_valid_o),
    .claim_i     (claim_i),
    .claim_id_i  (claim_id_i),
    .active_o    (active_o),
    .active_id_o (active_id_o),
    .complete_i  (complete_i),
    .claim_err_o (claim_err_o)
`ifdef IRQ_OVERRUN_EN
    ,
    .overrun_o   (overrun_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: history of raw samples, pending set, in-service line
  logic [N-1:0] hq[$];
  logic [N-1:0] m_pend, m_prev, m_esel, m_ovr;
  logic         m_err;
  int           m_svc;   // -1 when idle, else line number in service

  function automatic void model_reset();
    hq = {};
    for (int k = 0; k < S; k++) hq.push_front('0);
    m_pend = '0; m_prev = '0; m_esel = '0; m_ovr = '0;
    m_err = 1'b0; m_svc = -1;
  endfunction

  function automatic logic [N-1:0] vis_now();
    logic [N-1:0] hide;
    hide = (m_svc >= 0) ? (8'h01 << m_svc) : 8'h00;
    return m_pend & ~mask_i & ~hide;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] v;
    v = vis_now();
    chk("pend_o", pend_o, v);
    chk("req_valid_o", req_valid_o, (m_svc < 0) && (v != 0));
    chk("active_o", active_o, m_svc >= 0);
    chk("active_id_o", active_id_o, (m_svc >= 0) ? m_svc + 1 : 0);
    chk("claim_err_o", claim_err_o, m_err);
`ifdef IRQ_OVERRUN_EN
    chk("overrun_o", overrun_o, m_ovr);
`endif
  endtask

  // Advance one clock: predict from current inputs, clock, then compare
  task automatic step();
    logic [N-1:0] cur, rise, vis, nxt, ovr;
    logic [N-1:0] raw;
    logic         acc;
    int           id, svc_n;
    logic         err_n;
    if (!rst_n) begin
      @(posedge clk);
      model_reset();
    end else begin
      raw  = irq_i;
      cur  = hq[$];
      rise = cur & ~m_prev;
      vis  = vis_now();
      id   = int'(claim_id_i);
      acc  = (m_svc < 0) && claim_i && id >= 1 && id <= N && vis[id-1];
      ovr  = m_ovr;
      for (int i = 0; i < N; i++) begin
        if (edge_sel_i[i] != m_esel[i]) nxt[i] = 1'b0;
        else if (!edge_sel_i[i])        nxt[i] = cur[i];
        else if (rise[i])               nxt[i] = 1'b1;
        else if (acc && id == i + 1)    nxt[i] = 1'b0;
        else                            nxt[i] = m_pend[i];
        if (acc && id == i + 1) ovr[i] = 1'b0;
        else if (edge_sel_i[i] && edge_sel_i[i] == m_esel[i] && rise[i] && m_pend[i])
          ovr[i] = 1'b1;
      end
      err_n = m_err | (claim_i && ((m_svc < 0 && !acc) || (m_svc >= 0 && !complete_i)));
      svc_n = m_svc;
      if (m_svc < 0 && acc) svc_n = id - 1;
      else if (m_svc >= 0 && complete_i) svc_n = -1;
      m_esel = edge_sel_i;
      @(posedge clk);
      m_pend = nxt; m_prev = cur; m_ovr = ovr; m_err = err_n; m_svc = svc_n;
      hq.push_front(raw);
      void'(hq.pop_back());
    end
    #1;
    cycle++;
    check_all();
    $display("cyc %0d irq=%h esel=%h mask=%h claim=%0d/%0d cmpl=%0d -> pend=%h rv=%0d act=%0d id=%0d err=%0d",
             cycle, irq_i, edge_sel_i, mask_i, claim_i, claim_id_i, complete_i,
             pend_o, req_valid_o, active_o, active_id_o, claim_err_o);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic claim(input int code);
    claim_i = 1'b1; claim_id_i = IDW'(code);
    step();
    claim_i = 1'b0; claim_id_i = '0;
  endtask

  task automatic complete();
    complete_i = 1'b1;
    step();
    complete_i = 1'b0;
  endtask

  initial begin
    logic [N-1:0] v;
    int pick;
    model_reset();

    // Level mode with all lines high while held in reset
    irq_i = 8'hFF; edge_sel_i = 8'h00; rst_n = 1'b0;
    #2;
    chk("rst_pend", pend_o, 8'h00);
    chk("rst_rv", req_valid_o, 1'b0);
    chk("rst_act", active_o, 1'b0);
    chk("rst_err", claim_err_o, 1'b0);
    steps(2);
    rst_n = 1'b1;
    steps(2);
    chk("lvl_pend_early", pend_o, 8'h00);
    step();
    chk("lvl_pend", pend_o, 8'hFF);
    chk("lvl_rv", req_valid_o, 1'b1);
    claim(4);
    chk("lvl_claim_id", active_id_o, 4'd4);
    complete();

    // Edge line 5: single-cycle pulse, 3-cycle latency, claim then complete
    irq_i = 8'h00; edge_sel_i = 8'h20;
    steps(4);
    irq_i = 8'h20; step();
    irq_i = 8'h00; step(); step();
    chk("e5_pend", pend_o, 8'h20);
    claim(6);
    chk("e5_id", active_id_o, 4'd6);
    chk("e5_pend_svc", pend_o, 8'h00);
    chk("e5_rv_svc", req_valid_o, 1'b0);
    complete();
    chk("e5_act_done", active_o, 1'b0);

    // Lines 2 and 7 pending, line 7 masked: code 8 rejected, code 3 accepted
    edge_sel_i = 8'h84; mask_i = 8'h80;
    step();
    irq_i = 8'h84; step();
    irq_i = 8'h00; steps(3);
    chk("m_pend", pend_o, 8'h04);
    claim(8);
    chk("m_err", claim_err_o, 1'b1);
    chk("m_idle", active_o, 1'b0);
    claim(3);
    chk("m_id", active_id_o, 4'd3);
    complete();
    mask_i = 8'h00;
    step();

    // New edge on line 0 during its own service stays hidden until complete
    edge_sel_i = 8'h01; step();
    irq_i = 8'h01; step();
    irq_i = 8'h00; steps(3);
    claim(1);
    irq_i = 8'h01; step();
    irq_i = 8'h00; steps(4);
    chk("re_hidden", pend_o[0], 1'b0);
    complete();
    chk("re_visible", pend_o[0], 1'b1);
    chk("re_rv", req_valid_o, 1'b1);

    // Claim coincides with a new edge on the same line: set wins
    irq_i = 8'h01; step();
    irq_i = 8'h00; step();
    claim(1);
    complete();
    chk("setwins", pend_o[0], 1'b1);
    claim(1);
    complete();

`ifdef IRQ_OVERRUN_EN
    // Two edges before a claim raise overrun, which the claim clears
    irq_i = 8'h01; step(); irq_i = 8'h00; step();
    irq_i = 8'h01; step(); irq_i = 8'h00; steps(4);
    chk("ovr_set", overrun_o[0], 1'b1);
    claim(1);
    chk("ovr_clr", overrun_o[0], 1'b0);
    complete();
`endif

    // Asynchronous reset in the middle of a service with line 3 pending
    edge_sel_i = 8'h09; step();
    irq_i = 8'h09; step();
    irq_i = 8'h00; steps(3);
    claim(1);
    chk("ar_pend3", pend_o, 8'h08);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_pend", pend_o, 8'h00);
    chk("ar_act", active_o, 1'b0);
    chk("ar_id", active_id_o, 4'd0);
    chk("ar_err", claim_err_o, 1'b0);
    chk("ar_rv", req_valid_o, 1'b0);
    model_reset();
    step();
    rst_n = 1'b1;
    steps(2);
    chk("ar_after", pend_o, 8'h00);

    // Randomized traffic against the model
    for (int t = 0; t < 600; t++) begin
      irq_i = N'($urandom);
      if ($urandom_range(0, 40) == 0) edge_sel_i = N'($urandom);
      if ($urandom_range(0, 20) == 0) mask_i = N'($urandom) & N'($urandom);
      claim_i = ($urandom_range(0, 2) == 0);
      v = vis_now();
      if (v != 0 && $urandom_range(0, 3) != 0) begin
        pick = $urandom_range(0, N - 1);
        while (!v[pick]) pick = (pick + 1) % N;
        claim_id_i = IDW'(pick + 1);
      end else begin
        claim_id_i = IDW'($urandom_range(0, 15));
      end
      complete_i = ($urandom_range(0, 3) == 0);
      step();
    end
    claim_i = 1'b0; complete_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
